gray_img_server: RTL and testbench



---
 rtl/img_pkg.sv | 23 ++
 rtl/gray_mem.sv | 25 ++
 rtl/gray_img_server.sv | 98 +++++++++
 tb/tb_gray_img_server.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image geometry and server state encoding.
// Also supplies the {row,col} address packing used by the LBP engine.
package img_pkg;

   localparam int IMG_BITS = 7;
   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 2 * IMG_BITS;
   localparam int PIX_CNT  = 1 << ADDR_W;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_SERVE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [15:0] RD_MAX = 16'hFFFF;

   function automatic logic [ADDR_W-1:0] pix_addr(
      input logic [IMG_BITS-1:0] row,
      input logic [IMG_BITS-1:0] col
   );
      return {row, col};
   endfunction

endpackage

// File: rtl/gray_mem.sv
// Frame store: one synchronous write port, one asynchronous read port.
// Contents are never cleared; a frame is always overwritten in full.
module gray_mem
   import img_pkg::*;
(
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [PIX_CNT];

   // write the accepted pixel into its slot
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gray_img_server.sv
// Frame loader and zero-latency read responder for the LBP engine.
// LOAD fills memory, SERVE answers reads, DRAIN re-arms for next frame.
module gray_img_server
   import img_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_in_valid,
   input  logic [DATA_W-1:0] pix_in_data,
   output logic              pix_in_ready,
   output logic              gray_ready,
   input  logic              gray_req,
   input  logic [ADDR_W-1:0] gray_addr,
   output logic [DATA_W-1:0] gray_data,
   input  logic              finish,
   output logic              req_err,
   output logic [15:0]       rd_count
);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic              r_req_err;
   logic [15:0]       r_rd_count;

   logic              w_load;
   logic              w_serve;
   logic              w_drain;
   logic              w_wr;
   logic              w_last;
   logic [DATA_W-1:0] w_rd_data;

   assign w_load  = (r_state == ST_LOAD);
   assign w_serve = (r_state == ST_SERVE);
   assign w_drain = (r_state == ST_DRAIN);
   assign w_wr    = w_load & pix_in_valid;
   assign w_last  = (r_wr_ptr == ADDR_W'(PIX_CNT - 1));

   assign pix_in_ready = w_load;
   assign gray_ready   = w_serve;
   assign gray_data    = (w_serve & gray_req) ? w_rd_data : '0;
   assign req_err      = r_req_err;
   assign rd_count     = r_rd_count;

   gray_mem u_mem (
      .clk     (clk),
      .i_we    (w_wr),
      .i_waddr (r_wr_ptr),
      .i_wdata (pix_in_data),
      .i_raddr (gray_addr),
      .o_rdata (w_rd_data)
   );

   // frame state machine and write pointer; pointer wraps after last pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_LOAD;
         r_wr_ptr <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_wr) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (w_last) begin
                     r_state <= ST_SERVE;
                  end
               end
            end
            ST_SERVE: begin
               if (finish) begin
                  r_state <= ST_DRAIN;
               end
            end
            default: begin
               r_state <= ST_LOAD;
            end
         endcase
      end
   end

   // read counter and sticky early-request flag, both cleared leaving DRAIN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req_err  <= 1'b0;
         r_rd_count <= '0;
      end else if (w_drain) begin
         r_req_err  <= 1'b0;
         r_rd_count <= '0;
      end else begin
         if (gray_req & ~w_serve) begin
            r_req_err <= 1'b1;
         end
         if (gray_req & w_serve & (r_rd_count != RD_MAX)) begin
            r_rd_count <= r_rd_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_gray_img_server.sv
// Directed-vector bench for gray_img_server.
// Each task drives one scenario and checks its outputs inline.
module tb_gray_img_server;

   logic        clk;
   logic        reset;
   logic        pix_in_valid;
   logic [7:0]  pix_in_data;
   logic        pix_in_ready;
   logic        gray_ready;
   logic        gray_req;
   logic [13:0] gray_addr;
   logic [7:0]  gray_data;
   logic        finish;
   logic        req_err;
   logic [15:0] rd_count;

   int errs;
   int checks;

   gray_img_server dut (
      .clk          (clk),
      .reset        (reset),
      .pix_in_valid (pix_in_valid),
      .pix_in_data  (pix_in_data),
      .pix_in_ready (pix_in_ready),
      .gray_ready   (gray_ready),
      .gray_req     (gray_req),
      .gray_addr    (gray_addr),
      .gray_data    (gray_data),
      .finish       (finish),
      .req_err      (req_err),
      .rd_count     (rd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pix(input bit inv, input int a);
      logic [7:0] p;
      p = a[7:0];
      return inv ? (8'hFF - p) : p;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input bit inv, input bit tog, input int stop_after,
                         output int cyc, output int acc, output bit rdy_bad);
      bit v;
      cyc = 0;
      acc = 0;
      rdy_bad = 0;
      v = 1'b1;
      pix_in_valid = 1'b1;
      pix_in_data = pix(inv, 0);
      while (!gray_ready && acc < stop_after && cyc < 40000) begin
         #1;
         if (pix_in_ready !== 1'b1) rdy_bad = 1'b1;
         step();
         cyc++;
         if (v) acc++;
         if (tog) v = !v;
         pix_in_valid = v;
         pix_in_data = pix(inv, acc);
      end
      pix_in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      gray_req = 1'b1;
      gray_addr = 14'h0081;
      step();
      step();
      checks++; if (pix_in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got=%b want=1", pix_in_ready); end
      checks++; if (gray_ready !== 1'b0) begin errs++; $display("FAIL rst_gray_ready got=%b want=0", gray_ready); end
      checks++; if (req_err !== 1'b0) begin errs++; $display("FAIL rst_req_err got=%b want=0", req_err); end
      checks++; if (rd_count !== 16'd0) begin errs++; $display("FAIL rst_rd_count got=%0d want=0", rd_count); end
      checks++; if (gray_data !== 8'h00) begin errs++; $display("FAIL rst_gray_data got=%h want=00", gray_data); end
      gray_req = 1'b0;
      reset = 1'b0;
      step();
   endtask

   task automatic test_load_stream();
      int cyc, acc;
      bit rb;
      stream(1'b0, 1'b0, 16384, cyc, acc, rb);
      checks++; if (cyc !== 16384) begin errs++; $display("FAIL load_cycles got=%0d want=16384", cyc); end
      checks++; if (acc !== 16384) begin errs++; $display("FAIL load_accepts got=%0d want=16384", acc); end
      checks++; if (rb !== 1'b0) begin errs++; $display("FAIL load_ready_held got=%b want=0", rb); end
      checks++; if (gray_ready !== 1'b1) begin errs++; $display("FAIL serve_gray_ready got=%b want=1", gray_ready); end
      checks++; if (pix_in_ready !== 1'b0) begin errs++; $display("FAIL serve_pix_ready got=%b want=0", pix_in_ready); end
      gray_req = 1'b1;
      gray_addr = 14'h0081;
      #1;
      checks++; if (gray_data !== 8'h81) begin errs++; $display("FAIL rd_0081 got=%h want=81", gray_data); end
      step();
      gray_addr = 14'h3FFF;
      #1;
      checks++; if (gray_data !== 8'hFF) begin errs++; $display("FAIL rd_3fff got=%h want=ff", gray_data); end
      step();
      gray_addr = 14'h0100;
      #1;
      checks++; if (gray_data !== 8'h00) begin errs++; $display("FAIL rd_0100 got=%h want=00", gray_data); end
      step();
      gray_req = 1'b0;
      gray_addr = 14'h0081;
      #1;
      checks++; if (gray_data !== 8'h00) begin errs++; $display("FAIL rd_noreq got=%h want=00", gray_data); end
      checks++; if (rd_count !== 16'd3) begin errs++; $display("FAIL rd_count3 got=%0d want=3", rd_count); end
   endtask

   task automatic test_finish_priority();
      gray_req = 1'b1;
      gray_addr = 14'h0042;
      finish = 1'b1;
      #1;
      checks++; if (gray_data !== 8'h42) begin errs++; $display("FAIL fin_rd got=%h want=42", gray_data); end
      step();
      gray_req = 1'b0;
      finish = 1'b0;
      #1;
      checks++; if (gray_ready !== 1'b0) begin errs++; $display("FAIL drain_gray_ready got=%b want=0", gray_ready); end
      checks++; if (pix_in_ready !== 1'b0) begin errs++; $display("FAIL drain_pix_ready got=%b want=0", pix_in_ready); end
      checks++; if (rd_count !== 16'd4) begin errs++; $display("FAIL drain_rd_count got=%0d want=4", rd_count); end
      step();
      checks++; if (pix_in_ready !== 1'b1) begin errs++; $display("FAIL reload_pix_ready got=%b want=1", pix_in_ready); end
      checks++; if (rd_count !== 16'd0) begin errs++; $display("FAIL reload_rd_count got=%0d want=0", rd_count); end
   endtask

   task automatic test_toggle_load();
      int cyc, acc;
      bit rb;
      logic [13:0] a;
      stream(1'b0, 1'b1, 16384, cyc, acc, rb);
      checks++; if (cyc !== 32767) begin errs++; $display("FAIL tog_cycles got=%0d want=32767", cyc); end
      checks++; if (rb !== 1'b0) begin errs++; $display("FAIL tog_ready_held got=%b want=0", rb); end
      for (int i = 0; i < 10; i++) begin
         a = 14'(i * 16'h0677 + 3);
         gray_req = 1'b1;
         gray_addr = a;
         #1;
         checks++; if (gray_data !== a[7:0]) begin errs++; $display("FAIL tog_rd addr=%h got=%h want=%h", a, gray_data, a[7:0]); end
         step();
      end
      gray_req = 1'b0;
      finish = 1'b1;
      step();
      finish = 1'b0;
      #1;
      checks++; if (rd_count !== 16'd10) begin errs++; $display("FAIL drain_rd10 got=%0d want=10", rd_count); end
      checks++; if (gray_ready !== 1'b0) begin errs++; $display("FAIL drain10_gray_ready got=%b want=0", gray_ready); end
      step();
      checks++; if (rd_count !== 16'd0) begin errs++; $display("FAIL load_rd0 got=%0d want=0", rd_count); end
      checks++; if (pix_in_ready !== 1'b1) begin errs++; $display("FAIL load_pix_ready got=%b want=1", pix_in_ready); end
   endtask

   task automatic test_req_err();
      int cyc, acc;
      bit rb;
      gray_req = 1'b1;
      gray_addr = 14'h0000;
      #1;
      checks++; if (gray_data !== 8'h00) begin errs++; $display("FAIL early_rd got=%h want=00", gray_data); end
      step();
      gray_req = 1'b0;
      checks++; if (req_err !== 1'b1) begin errs++; $display("FAIL req_err_set got=%b want=1", req_err); end
      finish = 1'b1;
      step();
      finish = 1'b0;
      checks++; if (pix_in_ready !== 1'b1) begin errs++; $display("FAIL fin_in_load got=%b want=1", pix_in_ready); end
      stream(1'b0, 1'b0, 16384, cyc, acc, rb);
      checks++; if (gray_ready !== 1'b1) begin errs++; $display("FAIL err_serve got=%b want=1", gray_ready); end
      checks++; if (req_err !== 1'b1) begin errs++; $display("FAIL req_err_serve got=%b want=1", req_err); end
      finish = 1'b1;
      step();
      finish = 1'b0;
      checks++; if (req_err !== 1'b1) begin errs++; $display("FAIL req_err_drain got=%b want=1", req_err); end
      step();
      checks++; if (req_err !== 1'b0) begin errs++; $display("FAIL req_err_clear got=%b want=0", req_err); end
   endtask

   task automatic test_reset_midload();
      int cyc, acc;
      bit rb;
      stream(1'b0, 1'b0, 5000, cyc, acc, rb);
      checks++; if (acc !== 5000) begin errs++; $display("FAIL part_accepts got=%0d want=5000", acc); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (gray_ready !== 1'b0) begin errs++; $display("FAIL mid_rst_gray_ready got=%b want=0", gray_ready); end
      checks++; if (pix_in_ready !== 1'b1) begin errs++; $display("FAIL mid_rst_pix_ready got=%b want=1", pix_in_ready); end
      stream(1'b1, 1'b0, 16384, cyc, acc, rb);
      checks++; if (cyc !== 16384) begin errs++; $display("FAIL reload_cycles got=%0d want=16384", cyc); end
      gray_req = 1'b1;
      gray_addr = 14'h0005;
      #1;
      checks++; if (gray_data !== 8'hFA) begin errs++; $display("FAIL inv_0005 got=%h want=fa", gray_data); end
      step();
      gray_addr = 14'h1388;
      #1;
      checks++; if (gray_data !== 8'h77) begin errs++; $display("FAIL inv_1388 got=%h want=77", gray_data); end
      step();
      gray_addr = 14'h0000;
      #1;
      checks++; if (gray_data !== 8'hFF) begin errs++; $display("FAIL inv_0000 got=%h want=ff", gray_data); end
      step();
      gray_req = 1'b0;
      checks++; if (rd_count !== 16'd3) begin errs++; $display("FAIL inv_rd_count got=%0d want=3", rd_count); end
   endtask

   initial begin
      errs = 0;
      checks = 0;
      reset = 1'b1;
      pix_in_valid = 1'b0;
      pix_in_data = 8'h00;
      gray_req = 1'b0;
      gray_addr = 14'h0000;
      finish = 1'b0;
      test_reset();
      test_load_stream();
      test_finish_priority();
      test_toggle_load();
      test_req_err();
      test_reset_midload();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
